// File: rtl/hdmi_pkg.sv
// hdmi_pkg: mode/control encodings, island period lengths and island FSM states
// shared by the HDMI period scheduler and its position counter.
package hdmi_pkg;
   localparam logic [2:0] MODE_CONTROL      = 3'd0;
   localparam logic [2:0] MODE_VIDEO        = 3'd1;
   localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
   localparam logic [2:0] MODE_ISLAND       = 3'd3;
   localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;
   localparam logic [3:0] CTL_VIDEO_PREAMBLE  = 4'b0001;
   localparam logic [3:0] CTL_ISLAND_PREAMBLE = 4'b0101;
   localparam int PREAMBLE_LEN = 8;
   localparam int GUARD_LEN    = 2;
   localparam int PACKET_LEN   = 32;
   localparam int COOLDOWN_LEN = 4;
   // room a whole island needs, and room one more packet plus the island tail needs
   localparam int ISLAND_SPAN = PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN + COOLDOWN_LEN;
   localparam int PACKET_SPAN = PACKET_LEN + GUARD_LEN + COOLDOWN_LEN;
   typedef enum logic [2:0] {IDLE, PRE, LGB, DATA, TGB, COOL} island_state_t;
   function automatic logic line_precedes_active(input int y, input int frame_height,
                                                 input int screen_height);
      return (y + 1 < screen_height) || (y == frame_height - 1);
   endfunction
endpackage

// File: rtl/hdmi_position_counter.sv
// hdmi_position_counter: raster position, syncs and next-line-active flag.
// nx/ny expose the position the registers will show after the next edge.
module hdmi_position_counter
   import hdmi_pkg::*;
#(
   parameter int FRAME_WIDTH   = 800,
   parameter int FRAME_HEIGHT  = 525,
   parameter int SCREEN_HEIGHT = 480,
   parameter int HSYNC_START   = 656,
   parameter int HSYNC_SIZE    = 96,
   parameter int VSYNC_START   = 490,
   parameter int VSYNC_SIZE    = 2,
   localparam int XW = $clog2(FRAME_WIDTH),
   localparam int YW = $clog2(FRAME_HEIGHT)
) (
   input  logic          clk_pixel,
   input  logic          reset_n,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic          hsync,
   output logic          vsync,
   output logic          next_active,
   output logic [XW-1:0] nx,
   output logic [YW-1:0] ny
);
   logic started;
   logic x_wrap;

   // the first edge after reset presents pixel (0,0) rather than advancing past it
   always_comb begin
      x_wrap = int'(cx) == FRAME_WIDTH - 1;
      nx = !started || x_wrap ? '0 : cx + 1'b1;
      ny = !started ? '0 : !x_wrap ? cy : int'(cy) == FRAME_HEIGHT - 1 ? '0 : cy + 1'b1;
   end

   assign next_active = line_precedes_active(int'(cy), FRAME_HEIGHT, SCREEN_HEIGHT);

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         started <= 1'b0;
         cx      <= '0;
         cy      <= '0;
         hsync   <= 1'b0;
         vsync   <= 1'b0;
      end else begin
         started <= 1'b1;
         cx      <= nx;
         cy      <= ny;
         hsync   <= int'(nx) >= HSYNC_START && int'(nx) < HSYNC_START + HSYNC_SIZE;
         vsync   <= int'(ny) >= VSYNC_START && int'(ny) < VSYNC_START + VSYNC_SIZE;
      end
   end
endmodule

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: per-pixel TMDS period sequence (video, preambles, guard bands,
// data islands) with req/ack arbitration of blanking time for a packet source.
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int FRAME_WIDTH   = 800,
   parameter int FRAME_HEIGHT  = 525,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int HSYNC_START   = 656,
   parameter int HSYNC_SIZE    = 96,
   parameter int VSYNC_START   = 490,
   parameter int VSYNC_SIZE    = 2,
   parameter int MAX_PACKETS   = 18,
   localparam int XW = $clog2(FRAME_WIDTH),
   localparam int YW = $clog2(FRAME_HEIGHT),
   localparam int PW = $clog2(MAX_PACKETS + 1)
) (
   input  logic          clk_pixel,
   input  logic          reset_n,
   input  logic          packet_req,
   output logic          packet_ack,
   output logic [2:0]    mode,
   output logic [3:0]    ctl,
   output logic          hsync,
   output logic          vsync,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy
);
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          next_active;
   island_state_t state, ns;
   logic [4:0]    cnt, ncnt;
   logic [PW-1:0] pkts, npkts;
   logic [2:0]    mode_d;
   logic [3:0]    ctl_d;
   logic          ack_d;
   int            px, bound;
   logic          fit_island, fit_packet, last;
   logic          n_act, n_pre, v_pre, v_guard;

   hdmi_position_counter #(
      .FRAME_WIDTH(FRAME_WIDTH), .FRAME_HEIGHT(FRAME_HEIGHT), .SCREEN_HEIGHT(SCREEN_HEIGHT),
      .HSYNC_START(HSYNC_START), .HSYNC_SIZE(HSYNC_SIZE),
      .VSYNC_START(VSYNC_START), .VSYNC_SIZE(VSYNC_SIZE)
   ) u_pos (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .cy(cy), .hsync(hsync),
      .vsync(vsync), .next_active(next_active), .nx(nx), .ny(ny)
   );

   // an island may only be granted from a blanking pixel and must end before the preamble
   always_comb begin
      px         = int'(cx);
      bound      = next_active ? FRAME_WIDTH - 10 : FRAME_WIDTH;
      fit_island = !(px < SCREEN_WIDTH && int'(cy) < SCREEN_HEIGHT) && px != FRAME_WIDTH - 1
                   && px + 1 + ISLAND_SPAN <= bound;
      fit_packet = int'(pkts) < MAX_PACKETS && px + 1 + PACKET_SPAN <= bound;
      last       = int'(cnt) == (state == PRE ? PREAMBLE_LEN : state == DATA ? PACKET_LEN :
                                 state == COOL ? COOLDOWN_LEN : GUARD_LEN) - 1;
      ns    = state;
      ncnt  = last ? '0 : cnt + 1'b1;
      npkts = pkts;
      case (state)
         IDLE: begin
            ncnt  = '0;
            npkts = '0;
            if (packet_req && fit_island) begin
               ns    = PRE;
               npkts = PW'(1);
            end
         end
         PRE:  if (last) ns = LGB;
         LGB:  if (last) ns = DATA;
         DATA: if (last && packet_req && fit_packet) npkts = pkts + 1'b1;
               else if (last) ns = TGB;
         TGB:  if (last) ns = COOL;
         COOL: if (last) ns = IDLE;
         default: ns = IDLE;
      endcase
   end

   // outputs are computed for the pixel that the next edge will present
   always_comb begin
      n_act   = int'(nx) < SCREEN_WIDTH && int'(ny) < SCREEN_HEIGHT;
      n_pre   = line_precedes_active(int'(ny), FRAME_HEIGHT, SCREEN_HEIGHT);
      v_pre   = n_pre && int'(nx) >= FRAME_WIDTH - 10 && int'(nx) <= FRAME_WIDTH - 3;
      v_guard = n_pre && int'(nx) >= FRAME_WIDTH - 2;
      mode_d  = n_act ? MODE_VIDEO : v_pre ? MODE_CONTROL : v_guard ? MODE_VIDEO_GUARD :
                ns == DATA ? MODE_ISLAND : (ns == LGB || ns == TGB) ? MODE_ISLAND_GUARD :
                MODE_CONTROL;
      ctl_d   = n_act || v_guard ? 4'b0000 : v_pre ? CTL_VIDEO_PREAMBLE :
                ns == PRE ? CTL_ISLAND_PREAMBLE : 4'b0000;
      ack_d   = ns == DATA && ncnt == '0;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         pkts       <= '0;
         mode       <= MODE_CONTROL;
         ctl        <= 4'b0000;
         packet_ack <= 1'b0;
      end else begin
         state      <= ns;
         cnt        <= ncnt;
         pkts       <= npkts;
         mode       <= mode_d;
         ctl        <= ctl_d;
         packet_ack <= ack_d;
      end
   end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: directed checks of raster, preambles, island grants and reset.
// Frame height is shortened so a whole frame fits in a short run; widths stay at defaults.
module tb_hdmi_period_scheduler;
   import hdmi_pkg::*;
   localparam int FH = 30, SH = 20, VS = 22, VSZ = 2;
   localparam int XW = $clog2(800), YW = $clog2(FH);

   logic          clk_pixel = 1'b0, reset_n = 1'b0, packet_req = 1'b0;
   logic          ack1, ack2, hs1, hs2, vs1, vs2;
   logic [2:0]    mode1, mode2;
   logic [3:0]    ctl1, ctl2;
   logic [XW-1:0] cx1, cx2;
   logic [YW-1:0] cy1, cy2;
   int            n_assert = 0, n_fail = 0;

   always #5 clk_pixel = ~clk_pixel;

   hdmi_period_scheduler #(.FRAME_HEIGHT(FH), .SCREEN_HEIGHT(SH), .VSYNC_START(VS),
                           .VSYNC_SIZE(VSZ)) dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_req(packet_req), .packet_ack(ack1),
      .mode(mode1), .ctl(ctl1), .hsync(hs1), .vsync(vs1), .cx(cx1), .cy(cy1));

   hdmi_period_scheduler #(.FRAME_HEIGHT(FH), .SCREEN_HEIGHT(SH), .VSYNC_START(VS),
                           .VSYNC_SIZE(VSZ), .MAX_PACKETS(2)) dut2 (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_req(packet_req), .packet_ack(ack2),
      .mode(mode2), .ctl(ctl2), .hsync(hs2), .vsync(vs2), .cx(cx2), .cy(cy2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at cx=%0d cy=%0d", tag, obs, exp, cx1, cy1);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk_pixel);
   endtask

   task automatic goto(input int x, input int y);
      int k = 0;
      while (!(int'(cx1) == x && int'(cy1) == y) && k < 30000) begin
         @(negedge clk_pixel);
         k++;
      end
      check("goto_cx", cx1, x);
      check("goto_cy", cy1, y);
   endtask

   function automatic logic [2:0] em(input int o, input int n);
      return o < 8 ? 3'd0 : o < 10 ? 3'd4 : o < 10 + 32 * n ? 3'd3 : o < 12 + 32 * n ? 3'd4 : 3'd0;
   endfunction

   function automatic logic ea(input int o, input int n);
      return o >= 10 && o < 10 + 32 * n && (o - 10) % 32 == 0;
   endfunction

   // called with the first island pixel on the outputs; drop>0 releases req at that ack
   task automatic run_island(input int start, input int n1, input int n2, input int drop);
      for (int o = 0; o < 16 + 32 * n1; o++) begin
         check("isl_cx", cx1, start + o);
         check("isl_mode", mode1, em(o, n1));
         check("isl_ctl", ctl1, o < 8 ? 4'b0101 : 4'b0000);
         check("isl_ack", ack1, ea(o, n1));
         if (o < 16 + 32 * n2) begin
            check("isl2_mode", mode2, em(o, n2));
            check("isl2_ack", ack2, ea(o, n2));
         end
         if (drop > 0 && o == 10 + 32 * (drop - 1)) packet_req = 1'b0;
         step();
      end
   endtask

   initial begin
      int acks;
      step(2);
      check("rst_cx", cx1, 0);
      check("rst_cy", cy1, 0);
      check("rst_mode", mode1, 0);
      check("rst_ctl", ctl1, 0);
      check("rst_ack", ack1, 0);
      check("rst_hsync", hs1, 0);
      check("rst_vsync", vs1, 0);
      reset_n = 1'b1;
      step();
      check("first_cx", cx1, 0);
      check("first_mode", mode1, 1);
      step();
      check("adv_cx1", cx1, 1);
      step();
      check("adv_cx2", cx1, 2);
      check("adv_mode", mode1, 1);

      goto(655, 0);
      check("hsync_before", hs1, 0);
      step();
      check("hsync_first", hs1, 1);
      goto(751, 0);
      check("hsync_last", hs1, 1);
      step();
      check("hsync_after", hs1, 0);

      goto(789, 0);
      check("pre_before_mode", mode1, 0);
      check("pre_before_ctl", ctl1, 0);
      step();
      check("vpre_790_ctl", ctl1, 4'b0001);
      check("vpre_790_mode", mode1, 0);
      goto(797, 0);
      check("vpre_797_ctl", ctl1, 4'b0001);
      step();
      check("vguard_798", mode1, 2);
      check("vguard_798_ctl", ctl1, 0);
      step();
      check("vguard_799", mode1, 2);
      step();
      check("line1_cy", cy1, 1);
      check("line1_mode", mode1, 1);

      goto(640, 10);
      check("blank_640_mode", mode1, 0);
      packet_req = 1'b1;
      step();
      run_island(641, 1, 1, 1);

      goto(741, 11);
      packet_req = 1'b1;
      step();
      run_island(742, 1, 1, 1);
      check("fit_after_vpre", ctl1, 4'b0001);

      goto(742, 12);
      packet_req = 1'b1;
      step();
      check("nofit_743_ctl", ctl1, 0);
      check("nofit_743_state", dut.state, IDLE);
      goto(790, 12);
      check("nofit_790_ctl", ctl1, 4'b0001);
      goto(640, 13);
      check("regrant_640_mode", mode1, 0);
      check("regrant_640_ctl", ctl1, 0);
      step();
      run_island(641, 1, 1, 1);

      goto(789, 19);
      check("last_act_789", mode1, 0);
      step();
      check("last_act_790_mode", mode1, 0);
      check("last_act_790_ctl", ctl1, 0);
      goto(799, 19);
      check("last_act_799_mode", mode1, 0);
      check("last_act_799_ctl", ctl1, 0);
      step();
      check("blank_line_mode", mode1, 0);
      goto(799, VS - 1);
      check("vsync_before", vs1, 0);
      step();
      check("vsync_first", vs1, 1);
      goto(799, VS + VSZ - 1);
      check("vsync_last", vs1, 1);
      step();
      check("vsync_after", vs1, 0);

      goto(640, 24);
      packet_req = 1'b1;
      step();
      run_island(641, 4, 2, 0);
      packet_req = 1'b0;

      goto(790, FH - 1);
      check("wrap_vpre_ctl", ctl1, 4'b0001);
      goto(798, FH - 1);
      check("wrap_vguard", mode1, 2);
      step(2);
      check("wrap_cx", cx1, 0);
      check("wrap_cy", cy1, 0);
      check("wrap_mode", mode1, 1);

      goto(640, 1);
      packet_req = 1'b1;
      step();
      check("mid_pre_ctl", ctl1, 4'b0101);
      goto(661, 1);
      check("mid_data_mode", mode1, 3);
      reset_n = 1'b0;
      packet_req = 1'b0;
      #1;
      check("mid_rst_cx", cx1, 0);
      check("mid_rst_cy", cy1, 0);
      check("mid_rst_mode", mode1, 0);
      check("mid_rst_ctl", ctl1, 0);
      check("mid_rst_ack", ack1, 0);
      check("mid_rst_state", dut.state, IDLE);
      step();
      reset_n = 1'b1;
      step();
      check("mid_rel_mode", mode1, 1);
      acks = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         acks += int'(ack1);
      end
      check("mid_no_ack", acks, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
Generates the raster position and the per-pixel period sequence for the three TMDS channel encoders: control, video preamble, video guard band, active video, data island preamble, island guard bands and island packets. It also arbitrates blanking time for a packet source via a req/ack handshake, granting islands only where they fit before the next video preamble. It sits between the packet assembler and the tmds_channel instances, and drives their mode and control inputs.

Parameters:
FRAME_WIDTH, 800, total pixels per line
FRAME_HEIGHT, 525, total lines per frame
SCREEN_WIDTH, 640, active pixels per line (cx 0..SCREEN_WIDTH-1)
SCREEN_HEIGHT, 480, active lines (cy 0..SCREEN_HEIGHT-1)
HSYNC_START, 656, first cx with hsync=1
HSYNC_SIZE, 96, hsync length in pixels
VSYNC_START, 490, first cy with vsync=1
VSYNC_SIZE, 2, vsync length in lines
MAX_PACKETS, 18, maximum packets per island

Ports:
clk_pixel  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
packet_req  in  1  level; packet source has a 32-cycle packet ready
packet_ack  out  1  pulse on first data cycle of each granted packet
mode  out  3  0 control, 1 video, 2 video guard, 3 island data, 4 island guard
ctl  out  4  CTL3..CTL0 for channels 1/2 control_data
hsync  out  1  active-high
vsync  out  1  active-high
cx  out  $clog2(FRAME_WIDTH)  pixel position described by current outputs
cy  out  $clog2(FRAME_HEIGHT)  line position described by current outputs

Behaviour:
- Clock is clk_pixel. Reset is asynchronous, active-low, on reset_n.
- All outputs are registered and describe the same pixel (cx,cy). Reset values: cx=0, cy=0, mode=0, ctl=0, packet_ack=0, hsync=0, vsync=0, FSM=IDLE, packet count 0.
- Counters: cx wraps FRAME_WIDTH-1 to 0 and increments cy. cy wraps FRAME_HEIGHT-1 to 0.
- hsync=1 for cx in [HSYNC_START, HSYNC_START+HSYNC_SIZE). vsync=1 for cy in [VSYNC_START, VSYNC_START+VSYNC_SIZE).
- Active video: cx<SCREEN_WIDTH and cy<SCREEN_HEIGHT gives mode=1, ctl=0. This includes the first pixel after reset.
- next_active: cy+1<SCREEN_HEIGHT, or cy==FRAME_HEIGHT-1.
- When next_active is true:
  - cx in FRAME_WIDTH-10..FRAME_WIDTH-3: mode=0, ctl=4'b0001 (video preamble).
  - cx in FRAME_WIDTH-2..FRAME_WIDTH-1: mode=2.
- Boundary B: FRAME_WIDTH-10 if next_active, else FRAME_WIDTH. Islands never cross line end.
- Island FSM states and lengths: IDLE, PRE (8 cycles: mode=0, ctl=4'b0101), LGB (2: mode=4), DATA (32 per packet: mode=3), TGB (2: mode=4), COOL (4: mode=0, ctl=0), then back to IDLE.
- Grant: packet_req is sampled high in IDLE with the outputs at position p. The island then starts at s=p+1 only if all of the following hold:
  - s is not in active video;
  - s+48 <= B (44 island cycles plus 4 control cycles);
  - s is on the same line as p.
  Otherwise no grant; the source keeps waiting.
- packet_ack=1 exactly at DATA cycle 0 of each packet.
- Continuation: at DATA cycle 31, sample packet_req. Start another packet immediately if req=1, packets granted < MAX_PACKETS, and (next position)+38 <= B. Otherwise go to TGB. The packet count clears in IDLE.
- Active video and video preamble/guard override the island; the grant rule guarantees they never coincide.
- Simultaneous req and ack: a req held high through ack means the source has another packet.
- reset_n low at any point, including mid-island, returns everything to the reset values immediately. A packet in flight is abandoned without an ack.

Decomposition:
- Package hdmi_pkg holds:
  - mode encodings: MODE_CONTROL=0, MODE_VIDEO=1, MODE_VIDEO_GUARD=2, MODE_ISLAND=3, MODE_ISLAND_GUARD=4;
  - CTL_VIDEO_PREAMBLE=4'b0001, CTL_ISLAND_PREAMBLE=4'b0101;
  - PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, COOLDOWN_LEN=4;
  - island FSM state enum.
- Sub-module hdmi_position_counter produces cx, cy, hsync, vsync and next_active. The scheduler keeps the FSM, the fit check and the output mux.

Test Plan:
- Reset: hold reset_n=0 mid-frame -> cx=0, cy=0, mode=0, ctl=0, packet_ack=0. Release -> cx advances 0,1,2; mode=1 at (0,0).
- Video preamble (defaults): cy=0 -> cx 790..797 mode=0, ctl=0001; 798..799 mode=2; (0,1) mode=1. cy=479 -> no preamble, cx 790..799 mode=0, ctl=0. cy=524 -> preamble present.
- Single packet: req high at (640,10), dropped after ack -> PRE 641..648 ctl=0101; LGB 649..650; ack at 651; DATA 651..682; TGB 683..684; COOL 685..688.
- Fit boundary, active next line: req at cx=741 -> island starts 742. req first at cx=742 -> no island on that line; grant at (641, next line).
- Fit boundary, blank line (cy=500): req held from cx=640 -> 4 packets, ack at 651, 683, 715, 747, TGB 779..780. With MAX_PACKETS=2 -> 2 acks, TGB 715..716.
- Reset mid-island: reset_n low during DATA cycle 10 -> mode=0, ack=0, FSM IDLE, no ack for that packet after release.
